// File: rtl/load_extend_unit.sv
// Load-data extender for MEM/WB: lane select, zero/sign extension and alignment checking,
// followed by a 2-entry registered skid buffer with valid/ready handshakes.
module load_extend_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 5,
  parameter bit          BIG_ENDIAN = 1'b0,
  localparam int unsigned OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic [OFF_W-1:0]  inOffset,
  input  logic [1:0]        inSize,
  input  logic              inSigned,
  input  logic [TAG_W-1:0]  inTag,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [TAG_W-1:0]  outTag,
  output logic              outErr
);

  localparam int MAXSZ = OFF_W;
  localparam int unsigned ENT_W = DATA_W + TAG_W + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [DATA_W-1:0] lane, ext_data;
  logic              size_ok, misalign, err;
  logic [ENT_W-1:0]  new_ent;

  // Only inSize values up to MAXSZ are decoded; anything larger leaves size_ok low.
  always_comb begin
    lane     = '0;
    ext_data = '0;
    size_ok  = 1'b0;
    misalign = 1'b0;
    for (int s = 0; s <= MAXSZ && s < 4; s++) begin
      if (inSize == 2'(s)) begin
        size_ok  = 1'b1;
        misalign = |(inOffset & OFF_W'((1 << s) - 1));
        if (BIG_ENDIAN) lane = (inData << {inOffset, 3'b000}) >> (DATA_W - (8 << s));
        else            lane = inData >> {inOffset, 3'b000};
        for (int b = 0; b < int'(DATA_W); b++) begin
          if (b < (8 << s) || s == MAXSZ) ext_data[b] = lane[b];
          else                            ext_data[b] = inSigned & lane[(8 << s) - 1];
        end
      end
    end
  end

  assign err     = ~size_ok | misalign;
  assign new_ent = {err, inTag, err ? {DATA_W{1'b0}} : ext_data};

  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             accept, pop;

  assign inReady  = (count_q != ST_FULL) & ~flush;
  assign outValid = (count_q != ST_EMPTY);
  assign accept   = inValid & inReady;
  assign pop      = outValid & outReady;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = ST_EMPTY;
    end else begin
      case (count_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = new_ent;
            count_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_d = new_ent;
          end else if (accept) begin
            tail_d  = new_ent;
            count_d = ST_FULL;
          end else if (pop) begin
            count_d = ST_EMPTY;
          end
        end
        default: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = ST_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign outData = head_q[DATA_W-1:0];
  assign outTag  = head_q[DATA_W +: TAG_W];
  assign outErr  = head_q[ENT_W-1];

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed self-checking bench for load_extend_unit (DATA_W=32, little-endian).
module tb_load_extend_unit;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, inReady, inSigned, outValid, outReady, outErr;
  logic [31:0] inData, outData;
  logic [1:0]  inOffset, inSize;
  logic [4:0]  inTag, outTag;

  int n_checks = 0;
  int n_errors = 0;

  load_extend_unit #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .inOffset (inOffset),
    .inSize   (inSize),
    .inSigned (inSigned),
    .inTag    (inTag),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outTag   (outTag),
    .outErr   (outErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                       input logic sgn, input logic [4:0] tag);
    inValid  = 1'b1;
    inData   = d;
    inOffset = off;
    inSize   = sz;
    inSigned = sgn;
    inTag    = tag;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [4:0] popped[$];

  initial begin
    vecs[0]  = '{32'h1234_ABCD, 2'd0, 2'd1, 1'b1, 5'd1,  32'hFFFF_ABCD, 1'b0};
    vecs[1]  = '{32'h1234_ABCD, 2'd0, 2'd1, 1'b0, 5'd2,  32'h0000_ABCD, 1'b0};
    vecs[2]  = '{32'h1234_ABCD, 2'd2, 2'd1, 1'b1, 5'd3,  32'h0000_1234, 1'b0};
    vecs[3]  = '{32'h80FF_0000, 2'd3, 2'd0, 1'b1, 5'd4,  32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{32'h80FF_0000, 2'd3, 2'd0, 1'b0, 5'd5,  32'h0000_0080, 1'b0};
    vecs[5]  = '{32'h80FF_0000, 2'd2, 2'd0, 1'b1, 5'd6,  32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{32'h80FF_0000, 2'd0, 2'd2, 1'b1, 5'd7,  32'h80FF_0000, 1'b0};
    vecs[7]  = '{32'h80FF_0000, 2'd0, 2'd2, 1'b0, 5'd8,  32'h80FF_0000, 1'b0};
    vecs[8]  = '{32'h1234_ABCD, 2'd1, 2'd1, 1'b1, 5'd9,  32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h1234_ABCD, 2'd2, 2'd2, 1'b0, 5'd10, 32'h0000_0000, 1'b1};
    vecs[10] = '{32'h1234_ABCD, 2'd0, 2'd3, 1'b0, 5'd11, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'h1234_ABCD, 2'd1, 2'd0, 1'b0, 5'd12, 32'h0000_00AB, 1'b0};
    vecs[12] = '{32'h1234_ABCD, 2'd3, 2'd0, 1'b1, 5'd13, 32'h0000_0012, 1'b0};
    vecs[13] = '{32'h8765_4321, 2'd2, 2'd1, 1'b1, 5'd14, 32'hFFFF_8765, 1'b0};

    rst = 1'b1; flush = 1'b0; outReady = 1'b1;
    drive(32'h0, 2'd0, 2'd0, 1'b0, 5'd0);
    inValid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset outValid", 32'(outValid), 32'd0);
    chk("reset outData", outData, 32'd0);
    chk("reset outTag", 32'(outTag), 32'd0);
    chk("reset outErr", 32'(outErr), 32'd0);
    rst = 1'b0;
    #1 chk("reset inReady", 32'(inReady), 32'd1);

    // Back-to-back stream at outReady=1: one result per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].off, vecs[i].size, vecs[i].sgn, vecs[i].tag);
      cycle();
      chk($sformatf("vec%0d valid", i), 32'(outValid), 32'd1);
      chk($sformatf("vec%0d data", i), outData, vecs[i].exp_data);
      chk($sformatf("vec%0d err", i), 32'(outErr), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d tag", i), 32'(outTag), 32'(vecs[i].tag));
    end
    inValid = 1'b0;
    cycle();
    chk("drain outValid", 32'(outValid), 32'd0);

    // Stall: tags 1,2 fill the buffer, 3 waits; order kept after release.
    outReady = 1'b0;
    drive(32'h0000_0011, 2'd0, 2'd2, 1'b0, 5'd1);
    cycle();
    chk("stall inReady one", 32'(inReady), 32'd1);
    chk("stall head tag a", 32'(outTag), 32'd1);
    drive(32'h0000_0022, 2'd0, 2'd2, 1'b0, 5'd2);
    cycle();
    chk("stall inReady full", 32'(inReady), 32'd0);
    chk("stall head data a", outData, 32'h0000_0011);
    drive(32'h0000_0033, 2'd0, 2'd2, 1'b0, 5'd3);
    cycle();
    chk("stall inReady held", 32'(inReady), 32'd0);
    chk("stall head tag b", 32'(outTag), 32'd1);
    chk("stall head data b", outData, 32'h0000_0011);
    outReady = 1'b1;
    popped.delete();
    for (int k = 0; k < 8; k++) begin
      automatic logic will_acc = inValid & inReady;
      if (outValid) popped.push_back(outTag);
      @(posedge clk);
      #1;
      if (will_acc) inValid = 1'b0;
      @(negedge clk);
    end
    chk("stall pop count", 32'(popped.size()), 32'd3);
    for (int k = 0; k < 3 && k < popped.size(); k++)
      chk($sformatf("stall pop order %0d", k), 32'(popped[k]), 32'(k + 1));

    // Flush with a full buffer and a same-cycle request.
    outReady = 1'b0;
    drive(32'h0000_0044, 2'd0, 2'd2, 1'b0, 5'd4);
    cycle();
    drive(32'h0000_0055, 2'd0, 2'd2, 1'b0, 5'd5);
    cycle();
    drive(32'h0000_0066, 2'd0, 2'd2, 1'b0, 5'd6);
    flush = 1'b1;
    #1 chk("flush inReady", 32'(inReady), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    chk("flush outValid", 32'(outValid), 32'd0);
    cycle();
    cycle();
    chk("flush no ghost", 32'(outValid), 32'd0);
    drive(32'h0000_0077, 2'd0, 2'd2, 1'b0, 5'd7);
    cycle();
    inValid = 1'b0;
    chk("post flush valid", 32'(outValid), 32'd1);
    chk("post flush tag", 32'(outTag), 32'd7);
    cycle();

    // Reset mid-stream with a full buffer.
    outReady = 1'b0;
    drive(32'hDEAD_BEEF, 2'd0, 2'd2, 1'b0, 5'd8);
    cycle();
    drive(32'hCAFE_F00D, 2'd0, 2'd2, 1'b1, 5'd9);
    cycle();
    inValid = 1'b0;
    rst = 1'b1;
    cycle();
    chk("rst outValid", 32'(outValid), 32'd0);
    chk("rst outData", outData, 32'd0);
    chk("rst outTag", 32'(outTag), 32'd0);
    chk("rst outErr", 32'(outErr), 32'd0);
    rst = 1'b0;
    outReady = 1'b1;
    #1 chk("rst inReady", 32'(inReady), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(32'h8000_0000 | 32'(k), 2'd0, 2'd0, 1'b1, 5'(20 + k));
      cycle();
      chk($sformatf("rst stream %0d valid", k), 32'(outValid), 32'd1);
      chk($sformatf("rst stream %0d tag", k), 32'(outTag), 32'(20 + k));
      chk($sformatf("rst stream %0d data", k), outData, 32'(k));
    end
    inValid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
